// File: rtl/key_event_gen_if.sv
// Raw button pin in, debounced key level and one-cycle key-event strobes out.
interface key_event_gen_if;
    logic btn_in;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;

    modport master (
        input  btn_in,
        output key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
    modport slave (
        output btn_in,
        input  key_level, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_event_gen.sv
// Push-button front end: synchronise, debounce, and emit press/release/long/repeat strobes.
// Auto-repeat is built only when KEY_AUTOREPEAT_EN is defined; otherwise repeat_pulse is 0.
module key_event_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    key_event_gen_if.master bus
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic              IDLE_LVL  = ACTIVE_LOW;

    typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

    state_t              state;
    logic [1:0]          sync;
    logic [DB_W-1:0]     db_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                pressed, db_flip, rise, fall;

`ifdef KEY_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt;
`else
    assign bus.repeat_pulse = 1'b0;
`endif

    // Flip happens on the edge the mismatch count would reach DEBOUNCE_CYCLES.
    assign pressed = sync[1] ^ ACTIVE_LOW;
    assign db_flip = (pressed != bus.key_level) && (db_cnt == DB_LAST);
    assign rise    = db_flip && !bus.key_level;
    assign fall    = db_flip &&  bus.key_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync              <= {2{IDLE_LVL}};
            db_cnt            <= '0;
            hold_cnt          <= '0;
            state             <= IDLE;
            bus.key_level     <= 1'b0;
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.long_pulse    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt           <= '0;
            bus.repeat_pulse  <= 1'b0;
`endif
        end else begin
            sync              <= {sync[0], bus.btn_in};
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.long_pulse    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            bus.repeat_pulse  <= 1'b0;
`endif
            if (pressed == bus.key_level) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                db_cnt        <= '0;
                bus.key_level <= ~bus.key_level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            case (state)
                IDLE: if (rise) begin
                    state           <= PRESS;
                    bus.press_pulse <= 1'b1;
                    hold_cnt        <= '0;
                end
                PRESS: if (fall) begin
                    state             <= IDLE;
                    bus.release_pulse <= 1'b1;
                    hold_cnt          <= '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    // First repeat coincides with the long-press strobe.
                    state          <= HOLD;
                    bus.long_pulse <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    bus.repeat_pulse <= 1'b1;
                    rep_cnt          <= '0;
`endif
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                HOLD: if (fall) begin
                    state             <= IDLE;
                    bus.release_pulse <= 1'b1;
                    hold_cnt          <= '0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt           <= '0;
                end else if (rep_cnt == REP_LAST) begin
                    bus.repeat_pulse <= 1'b1;
                    rep_cnt          <= '0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_event_gen.sv
// Randomised and directed bench for key_event_gen with a window/arithmetic reference model and event scoreboard.
`timescale 1ns/1ps
module tb_key_event_gen;
    localparam int D = 4, L = 20, R = 5, MAXC = 4000;

    typedef struct {
        int       cyc;
        bit [3:0] mask;   // {repeat, long, release, press}
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    key_event_gen_if kif();

    key_event_gen #(
        .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .bus(kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus history: ph[k] = pin reads "pressed" before edge k, ra[k] = rst high at edge k.
    bit   ph [0:MAXC];
    bit   ra [0:MAXC];
    bit   m_key = 1'b0;
    int   m_p = -1, m_r = 0;
    ev_t  evq[$];
    bit   keyq[$];

    // Key level flips at edge k when the synchronised samples of the last D edges
    // (all after the latest reset) disagree with the current level.
    task automatic model(input int k);
        bit flip, s;
        bit [3:0] ev;
        ev_t e;
        ev = '0;
        if (ra[k]) begin
            m_key = 1'b0; m_p = -1; m_r = k;
        end else begin
            flip = 1'b1;
            for (int j = k - D + 1; j <= k; j++) begin
                if (j <= m_r) flip = 1'b0;
                else begin
                    s = (j - 2 <= m_r) ? 1'b0 : ph[j-2];
                    if (s == m_key) flip = 1'b0;
                end
            end
            if (flip) begin
                if (!m_key) begin ev[0] = 1'b1; m_p = k; end
                else begin ev[1] = 1'b1; m_p = -1; end
                m_key = ~m_key;
            end else if (m_key && m_p >= 0) begin
                if (k == m_p + L) ev[2] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                if (k >= m_p + L && ((k - m_p - L) % R) == 0) ev[3] = 1'b1;
`endif
            end
        end
        keyq.push_back(m_key);
        if (ev != 0) begin
            e.cyc = k; e.mask = ev;
            evq.push_back(e);
        end
    endtask

    task automatic step(input bit pin, input bit r);
        int k;
        k = cyc + 1;
        if (k > MAXC) begin
            $display("FAIL cycle_budget: cycle %0d exceeds %0d", k, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        kif.btn_in = pin;
        rst        = r;
        ph[k]      = ~pin;
        ra[k]      = r;
        model(k);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", nm, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle key level, and pulse events matched against the event queue.
    always @(negedge clk) begin
        bit       ek;
        ev_t      e;
        bit [3:0] dmask;
        if (keyq.size() > 0) begin
            ek = keyq.pop_front();
            chk("key_level", {3'b0, kif.key_level}, {3'b0, ek});
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                n_chk++; n_fail++;
                $display("FAIL missed_event at cycle %0d: got none, expected mask %b at cycle %0d",
                         cyc, e.mask, e.cyc);
            end
            dmask = {kif.repeat_pulse, kif.long_pulse, kif.release_pulse, kif.press_pulse};
            if (dmask != 0) begin
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    e = evq.pop_front();
                    chk("pulses", dmask, e.mask);
                end else begin
                    chk("unexpected_pulse", dmask, 4'b0);
                end
            end
        end
    end

    initial begin
        kif.btn_in = 1'b1;
        rst        = 1'b1;
        repeat (3)  step(1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        // Bounce then settle pressed, hold past long/repeat, release.
        for (int i = 0; i < 12; i++) step(((i / 2) % 2) == 1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        // Short glitch on idle pin.
        repeat (3)  step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        // Long hold: 60 cycles after the press.
        repeat (66) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        // Short press released at P+12.
        repeat (18) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        // Reset at P+22 with the pin still held.
        repeat (28) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b0);
        // Release glitch while held, then release.
        repeat (2)  step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        // Random runs with occasional reset.
        for (int i = 0; i < 40; i++) begin
            int len;
            bit p;
            len = $urandom_range(1, 30);
            p   = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++) step(p, $urandom_range(0, 199) == 0);
        end
        repeat (15) step(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("events_drained", 4'(evq.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
